// File: rtl/axis2fifo_pack.sv
`timescale 1ns/1ps
// axis2fifo_pack: packs AXI-Stream pixels into FIFO words, first pixel in LSBs.
// Words are aligned to start-of-frame; short lines and mid-word restarts raise pack_err.
// Optional statistics outputs (frame_cnt, drop_cnt) are built when AXIS2FIFO_PACK_STAT_EN is defined.
// Handshake: a beat is transferred on a rising edge where s_axis_tvalid and s_axis_tready are both 1;
// a packed word is transferred to the FIFO on a rising edge where fifo_wr_en is 1.
module axis2fifo_pack #(
   parameter int C_PIXEL_WIDTH = 8,
   parameter int C_DATA_WIDTH  = 32
) (
   input  logic                     S_AXIS_ACLK,
   input  logic                     S_AXIS_ARESET,
   input  logic                     soft_resetn,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
   input  logic                     s_axis_tuser,
   input  logic                     s_axis_tlast,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [C_DATA_WIDTH-1:0]  fifo_dout,
   output logic                     fifo_sof,
   output logic                     pack_err,
`ifdef AXIS2FIFO_PACK_STAT_EN
   output logic [15:0]              frame_cnt,
   output logic [15:0]              drop_cnt,
`endif
   output logic                     dbg_state_o
);

   // Pixel slot geometry: each pixel occupies a byte-aligned slot of 1, 2 or 4 bytes.
   localparam int PB        = (C_PIXEL_WIDTH <= 8) ? 1 : ((C_PIXEL_WIDTH <= 16) ? 2 : 4);
   localparam int SLOT_W    = PB * 8;
   localparam int N         = C_DATA_WIDTH / SLOT_W;
   localparam int SW        = (N > 1) ? $clog2(N) : 1;
   localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);

   typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [SW-1:0]           slot_q, slot_d;
   logic [C_DATA_WIDTH-1:0] acc_q, acc_d;
   logic                    acc_sof_q, acc_sof_d;
   logic                    out_valid_q, out_valid_d;
   logic [C_DATA_WIDTH-1:0] dout_q, dout_d;
   logic                    sof_q, sof_d;
   logic                    err_q, err_d;

   logic                    accept;
   logic                    wr;
   logic [C_DATA_WIDTH-1:0] pix0;
   logic [C_DATA_WIDTH-1:0] pix_slot;
   logic [C_DATA_WIDTH-1:0] word_c;
   logic [SW-1:0]           fill_c;
   logic                    wsof_c;

   // In SYNC the stream is always drained; in RUN it stalls only when the output word cannot leave.
   assign s_axis_tready = ~S_AXIS_ARESET & soft_resetn &
                          ((state_q == ST_SYNC) | ~out_valid_q | ~fifo_full);
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign wr            = out_valid_q & ~fifo_full;
   assign fifo_wr_en    = wr;
   assign fifo_dout     = dout_q;
   assign fifo_sof      = sof_q;
   assign pack_err      = err_q;
   assign dbg_state_o   = (state_q == ST_RUN);

   // Position the incoming pixel at slot 0 and at the current slot, zero-extended.
   always_comb begin
      pix0 = '0;
      pix0[C_PIXEL_WIDTH-1:0] = s_axis_tdata;
      pix_slot = '0;
      for (int k = 0; k < N; k++) begin
         if (slot_q == SW'(k)) pix_slot[k*SLOT_W +: C_PIXEL_WIDTH] = s_axis_tdata;
      end
   end

   // Next-state: frame sync, slot packing, word completion and output register handoff.
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      acc_d       = acc_q;
      acc_sof_d   = acc_sof_q;
      out_valid_d = out_valid_q & ~wr;
      dout_d      = dout_q;
      sof_d       = sof_q;
      err_d       = 1'b0;
      word_c      = '0;
      fill_c      = '0;
      wsof_c      = 1'b0;
      if (!soft_resetn) begin
         state_d     = ST_SYNC;
         slot_d      = '0;
         acc_d       = '0;
         acc_sof_d   = 1'b0;
         out_valid_d = 1'b0;
      end else if (accept && (state_q == ST_RUN || s_axis_tuser)) begin
         if (s_axis_tuser) begin
            // Start of frame restarts the word; any partial word is abandoned.
            if (state_q == ST_RUN && slot_q != '0) err_d = 1'b1;
            word_c = pix0;
            fill_c = '0;
            wsof_c = 1'b1;
         end else begin
            word_c = acc_q | pix_slot;
            fill_c = slot_q;
            wsof_c = acc_sof_q;
         end
         state_d = ST_RUN;
         if (fill_c == LAST_SLOT || s_axis_tlast) begin
            if (fill_c != LAST_SLOT) err_d = 1'b1;
            out_valid_d = 1'b1;
            dout_d      = word_c;
            sof_d       = wsof_c;
            slot_d      = '0;
            acc_d       = '0;
            acc_sof_d   = 1'b0;
         end else begin
            slot_d    = fill_c + 1'b1;
            acc_d     = word_c;
            acc_sof_d = wsof_c;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
      if (S_AXIS_ARESET) begin
         state_q     <= ST_SYNC;
         slot_q      <= '0;
         acc_q       <= '0;
         acc_sof_q   <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         sof_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         acc_q       <= acc_d;
         acc_sof_q   <= acc_sof_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         sof_q       <= sof_d;
         err_q       <= err_d;
      end
   end

`ifdef AXIS2FIFO_PACK_STAT_EN
   // Frames written (wrapping) and beats dropped while waiting for sync (saturating).
   always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
      if (S_AXIS_ARESET) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (wr && sof_q) frame_cnt <= frame_cnt + 16'd1;
         if (accept && state_q == ST_SYNC && !s_axis_tuser && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis2fifo_pack.sv
`timescale 1ns/1ps
// Bench for axis2fifo_pack: directed scenarios plus randomized traffic against a
// queue-based model of packed words, with a second 10-bit-pixel instance.
module tb_axis2fifo_pack;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst, soft_resetn, tvalid, tready, tuser, tlast, full;
   logic        wr_en, sof, perr, dbg;
   logic [7:0]  tdata;
   logic [31:0] dout;
   logic        tvalid10, tready10, tuser10, tlast10, full10, wr10, sof10, perr10, dbg10;
   logic [9:0]  tdata10;
   logic [31:0] dout10;
`ifdef AXIS2FIFO_PACK_STAT_EN
   logic [15:0] frame_cnt, drop_cnt, frame_cnt10, drop_cnt10;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] exp_q[$];
   logic        exp_sof_q[$];
   logic [7:0]  cur_q[$];
   logic        cur_sof;
   bit          in_frame;
   bit          mon_en;
   int          err_exp, err_seen, drops_exp, frames_exp;
   logic        m_exp_wr, m_exp_tr, m_s, m_e;
   logic [31:0] m_w, m_got_w;

   axis2fifo_pack #(.C_PIXEL_WIDTH(8), .C_DATA_WIDTH(32)) u_dut (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .soft_resetn(soft_resetn),
      .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
      .s_axis_tuser(tuser), .s_axis_tlast(tlast), .fifo_full(full),
      .fifo_wr_en(wr_en), .fifo_dout(dout), .fifo_sof(sof), .pack_err(perr),
`ifdef AXIS2FIFO_PACK_STAT_EN
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
`endif
      .dbg_state_o(dbg)
   );

   axis2fifo_pack #(.C_PIXEL_WIDTH(10), .C_DATA_WIDTH(32)) u_dut10 (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .soft_resetn(1'b1),
      .s_axis_tvalid(tvalid10), .s_axis_tready(tready10), .s_axis_tdata(tdata10),
      .s_axis_tuser(tuser10), .s_axis_tlast(tlast10), .fifo_full(full10),
      .fifo_wr_en(wr10), .fifo_dout(dout10), .fifo_sof(sof10), .pack_err(perr10),
`ifdef AXIS2FIFO_PACK_STAT_EN
      .frame_cnt(frame_cnt10), .drop_cnt(drop_cnt10),
`endif
      .dbg_state_o(dbg10)
   );

   // Clock
   always #5 clk = ~clk;

   // Monitor and scoreboard: compares every cycle against the model, then advances the model.
   always @(negedge clk) begin
      if (mon_en) begin
         m_exp_wr = (exp_q.size() > 0) && !full;
         m_exp_tr = soft_resetn && (!in_frame || exp_q.size() == 0 || !full);
         checks++;
         if (wr_en !== m_exp_wr) begin
            errors++; $display("FAIL mon_wr_en: got %b expected %b at %0t", wr_en, m_exp_wr, $time);
         end
         checks++;
         if (tready !== m_exp_tr) begin
            errors++; $display("FAIL mon_tready: got %b expected %b at %0t", tready, m_exp_tr, $time);
         end
         if (wr_en === 1'b1 && exp_q.size() > 0) begin
            m_w = exp_q.pop_front();
            m_s = exp_sof_q.pop_front();
            m_got_w = dout;
            if (m_s) frames_exp++;
            checks++;
            if (m_got_w !== m_w) begin
               errors++; $display("FAIL mon_dout: got %h expected %h at %0t", m_got_w, m_w, $time);
            end
            checks++;
            if (sof !== m_s) begin
               errors++; $display("FAIL mon_sof: got %b expected %b at %0t", sof, m_s, $time);
            end
         end
         if (perr === 1'b1) err_seen++;
         if (!soft_resetn) begin
            exp_q.delete(); exp_sof_q.delete(); cur_q.delete();
            in_frame = 0; cur_sof = 0;
         end else if (tvalid === 1'b1 && tready === 1'b1) begin
            if (!in_frame && !tuser) begin
               drops_exp++;
            end else begin
               m_e = 0;
               if (tuser) begin
                  if (cur_q.size() > 0) m_e = 1;
                  cur_q.delete();
                  in_frame = 1;
                  cur_sof = 1;
               end
               cur_q.push_back(tdata);
               if (cur_q.size() == N || tlast) begin
                  if (cur_q.size() < N) m_e = 1;
                  m_w = '0;
                  foreach (cur_q[k]) m_w = m_w | (32'(cur_q[k]) << (8 * k));
                  exp_q.push_back(m_w);
                  exp_sof_q.push_back(cur_sof);
                  cur_q.delete();
                  cur_sof = 0;
               end
               if (m_e) err_exp++;
            end
         end
      end
   end

   // Driver: present one beat and hold it until accepted (bounded).
   task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
      bit done;
      done = 0;
      tvalid = 1; tdata = d; tuser = u; tlast = l;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (tready === 1'b1) done = 1;
         @(posedge clk); #1;
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL send_beat_timeout: data %h never accepted", d);
      end
      tvalid = 0; tuser = 0; tlast = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_model();
      exp_q.delete(); exp_sof_q.delete(); cur_q.delete();
      in_frame = 0; cur_sof = 0; drops_exp = 0; frames_exp = 0;
   endtask

   task automatic test_reset();
      rst = 1; soft_resetn = 1; tvalid = 0; tdata = 0; tuser = 0; tlast = 0; full = 0;
      tvalid10 = 0; tdata10 = 0; tuser10 = 0; tlast10 = 0; full10 = 0;
      mon_en = 0; err_exp = 0; err_seen = 0; clear_model();
      #2;
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b expected 0", tready); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_dout: got %h expected 0", dout); end
      checks++; if (sof !== 1'b0) begin errors++; $display("FAIL rst_sof: got %b expected 0", sof); end
      checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rst_pack_err: got %b expected 0", perr); end
      checks++; if (dbg !== 1'b0) begin errors++; $display("FAIL rst_state: got %b expected SYNC", dbg); end
      repeat (3) @(posedge clk);
      #1 rst = 0; mon_en = 1;
      #1;
      checks++; if (tready !== 1'b1) begin errors++; $display("FAIL sync_tready: got %b expected 1", tready); end
   endtask

   task automatic test_basic();
      send_beat(8'h11, 1, 0); send_beat(8'h22, 0, 0); send_beat(8'h33, 0, 0); send_beat(8'h44, 0, 0);
      checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr_en: got %b expected 1", wr_en); end
      checks++; if (dout !== 32'h44332211) begin errors++; $display("FAIL basic_dout: got %h expected 44332211", dout); end
      checks++; if (sof !== 1'b1) begin errors++; $display("FAIL basic_sof: got %b expected 1", sof); end
      idle(1);
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL basic_single_write: got %b expected 0", wr_en); end
   endtask

   task automatic test_drop();
      soft_resetn = 0;
      idle(1);
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL soft_tready: got %b expected 0", tready); end
      soft_resetn = 1;
      send_beat(8'h01, 0, 0); send_beat(8'h02, 0, 0); send_beat(8'h03, 0, 0);
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL drop_wr_en: got %b expected 0", wr_en); end
      checks++; if (dbg !== 1'b0) begin errors++; $display("FAIL drop_state: got %b expected SYNC", dbg); end
`ifdef AXIS2FIFO_PACK_STAT_EN
      checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL drop_cnt: got %0d expected 3", drop_cnt); end
`endif
      send_beat(8'hA1, 1, 0); send_beat(8'hA2, 0, 0); send_beat(8'hA3, 0, 0); send_beat(8'hA4, 0, 0);
      checks++; if (dout !== 32'hA4A3A2A1 || sof !== 1'b1 || wr_en !== 1'b1) begin
         errors++; $display("FAIL drop_frame: got wr %b dout %h sof %b expected 1 a4a3a2a1 1", wr_en, dout, sof);
      end
   endtask

   task automatic test_tlast();
      send_beat(8'hAA, 0, 0); send_beat(8'hBB, 0, 1);
      checks++; if (dout !== 32'h0000BBAA || wr_en !== 1'b1) begin
         errors++; $display("FAIL tlast_dout: got wr %b dout %h expected 1 0000bbaa", wr_en, dout);
      end
      checks++; if (sof !== 1'b0) begin errors++; $display("FAIL tlast_sof: got %b expected 0", sof); end
      checks++; if (perr !== 1'b1) begin errors++; $display("FAIL tlast_err: got %b expected 1", perr); end
      idle(1);
      checks++; if (perr !== 1'b0) begin errors++; $display("FAIL tlast_err_pulse: got %b expected 0", perr); end
   endtask

   task automatic test_full();
      full = 1;
      send_beat(8'hC1, 0, 0); send_beat(8'hC2, 0, 0); send_beat(8'hC3, 0, 0); send_beat(8'hC4, 0, 0);
      tvalid = 1; tdata = 8'hD1; tuser = 0; tlast = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (tready !== 1'b0 || wr_en !== 1'b0 || dout !== 32'hC4C3C2C1) begin
            errors++; $display("FAIL full_hold: cycle %0d got tready %b wr %b dout %h expected 0 0 c4c3c2c1", i, tready, wr_en, dout);
         end
      end
      @(posedge clk); #1 full = 0;
      @(negedge clk);
      checks++; if (wr_en !== 1'b1 || tready !== 1'b1) begin
         errors++; $display("FAIL full_release: got wr %b tready %b expected 1 1", wr_en, tready);
      end
      @(posedge clk); #1 tvalid = 0;
      @(negedge clk);
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL full_one_write: got %b expected 0", wr_en); end
      @(posedge clk); #1;
      send_beat(8'hD2, 0, 0); send_beat(8'hD3, 0, 0); send_beat(8'hD4, 0, 0);
      checks++; if (dout !== 32'hD4D3D2D1 || sof !== 1'b0) begin
         errors++; $display("FAIL full_next_word: got dout %h sof %b expected d4d3d2d1 0", dout, sof);
      end
   endtask

   task automatic test_tuser_mid();
      send_beat(8'h51, 0, 0); send_beat(8'h52, 0, 0); send_beat(8'h77, 1, 0);
      checks++; if (perr !== 1'b1 || wr_en !== 1'b0) begin
         errors++; $display("FAIL tuser_mid_err: got err %b wr %b expected 1 0", perr, wr_en);
      end
      send_beat(8'h78, 0, 0); send_beat(8'h79, 0, 0); send_beat(8'h7A, 0, 0);
      checks++; if (dout !== 32'h7A797877 || sof !== 1'b1) begin
         errors++; $display("FAIL tuser_mid_word: got dout %h sof %b expected 7a797877 1", dout, sof);
      end
   endtask

   task automatic test_soft_reset();
      send_beat(8'h61, 0, 0); send_beat(8'h62, 0, 0);
      soft_resetn = 0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (tready !== 1'b0 || wr_en !== 1'b0 || dbg !== 1'b0) begin
         errors++; $display("FAIL soft_mid: got tready %b wr %b state %b expected 0 0 0", tready, wr_en, dbg);
      end
      @(posedge clk); #1 soft_resetn = 1;
      send_beat(8'h81, 1, 0); send_beat(8'h82, 0, 0); send_beat(8'h83, 0, 0); send_beat(8'h84, 0, 0);
      checks++; if (dout !== 32'h84838281 || sof !== 1'b1) begin
         errors++; $display("FAIL soft_restart: got dout %h sof %b expected 84838281 1", dout, sof);
      end
   endtask

   task automatic test_reset_mid();
      send_beat(8'h91, 1, 0); send_beat(8'h92, 0, 0);
      #2 rst = 1; mon_en = 0;
      #1;
      checks++; if (tready !== 1'b0 || wr_en !== 1'b0 || dout !== 32'h0 || sof !== 1'b0 || dbg !== 1'b0) begin
         errors++; $display("FAIL async_reset: got tready %b wr %b dout %h sof %b state %b expected all 0", tready, wr_en, dout, sof, dbg);
      end
      clear_model();
      @(posedge clk); #1 rst = 0; mon_en = 1;
      send_beat(8'h93, 1, 0); send_beat(8'h94, 0, 0); send_beat(8'h95, 0, 0); send_beat(8'h96, 0, 0);
      checks++; if (dout !== 32'h96959493 || sof !== 1'b1) begin
         errors++; $display("FAIL reset_restart: got dout %h sof %b expected 96959493 1", dout, sof);
      end
   endtask

   task automatic test_pw10();
      bit ok;
      for (int i = 0; i < 2; i++) begin
         tvalid10 = 1; tdata10 = (i == 0) ? 10'h3FF : 10'h155; tuser10 = (i == 0);
         ok = 0;
         for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = (tready10 === 1'b1);
            @(posedge clk); #1;
         end
         checks++;
         if (!ok) begin errors++; $display("FAIL pw10_timeout: beat %0d not accepted", i); end
      end
      tvalid10 = 0; tuser10 = 0;
      checks++; if (wr10 !== 1'b1 || sof10 !== 1'b1) begin
         errors++; $display("FAIL pw10_write: got wr %b sof %b expected 1 1", wr10, sof10);
      end
      checks++; if (dout10[9:0] !== 10'h3FF || dout10[15:10] !== 6'h0) begin
         errors++; $display("FAIL pw10_slot0: got %h expected 3ff with zero pad", dout10[15:0]);
      end
      checks++; if (dout10 !== 32'h015503FF) begin
         errors++; $display("FAIL pw10_word: got %h expected 015503ff", dout10);
      end
   endtask

   task automatic test_random();
      bit acc;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         acc = (tvalid === 1'b1) && (tready === 1'b1);
         @(posedge clk); #1;
         if (!tvalid || acc) begin
            tvalid = ($urandom_range(0, 3) != 0);
            tdata  = 8'($urandom);
            tuser  = ($urandom_range(0, 11) == 0);
            tlast  = ($urandom_range(0, 6) == 0);
         end
         full        = ($urandom_range(0, 3) == 0);
         soft_resetn = ($urandom_range(0, 199) != 0);
      end
      @(posedge clk); #1;
      tvalid = 0; tuser = 0; tlast = 0; full = 0; soft_resetn = 1;
      idle(5);
      checks++; if (exp_q.size() != 0) begin
         errors++; $display("FAIL rand_drain: %0d words never written, expected 0", exp_q.size());
      end
      checks++; if (err_seen != err_exp) begin
         errors++; $display("FAIL rand_pack_err: got %0d pulses expected %0d", err_seen, err_exp);
      end
`ifdef AXIS2FIFO_PACK_STAT_EN
      checks++; if (frame_cnt !== 16'(frames_exp) || drop_cnt !== 16'(drops_exp)) begin
         errors++; $display("FAIL rand_stats: got frames %0d drops %0d expected %0d %0d", frame_cnt, drop_cnt, frames_exp, drops_exp);
      end
`endif
   endtask

   // Watchdog
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   // Sequence
   initial begin
      test_reset();
      test_basic();
      test_drop();
      test_tlast();
      test_full();
      test_tuser_mid();
      test_soft_reset();
      test_reset_mid();
      test_pw10();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
